// File: rtl/smi_mem_fuzz_test_sequencer_pkg.sv
// Shared types and constants for the memory fuzz-test campaign sequencer.
package smi_mem_fuzz_test_sequencer_pkg;

  localparam logic [31:0] DefaultTimeoutCycles = 32'd16777216;
  localparam int ResultWidth = 114;

  typedef enum logic [2:0] {
    Reset       = 3'd0,
    Idle        = 3'd1,
    IssueConfig = 3'd2,
    WaitStatus  = 3'd3,
    Report      = 3'd4
  } state_e;

  // Packed so it maps bit-for-bit onto the 114-bit result buffer.
  typedef struct packed {
    logic        pass;
    logic        timeout;
    logic [15:0] runsDone;
    logic [31:0] errorTotal;
    logic [63:0] dataTotal;
  } result_t;

  function automatic logic [31:0] satAdd32(logic [31:0] a, logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFFFFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/smi_mem_fuzz_test_sequencer_if.sv
// Campaign request, fuzz-tester config/status and campaign result channels.
interface smi_mem_fuzz_test_sequencer_if;

  logic        startValid;
  logic [63:0] startAddrBase;
  logic [31:0] startBlockSize;
  logic [31:0] startNumTests;
  logic [15:0] startNumRuns;
  logic        startStop;

  logic        configValid;
  logic [63:0] configMemAddrBase;
  logic [31:0] configMemBlockSize;
  logic [31:0] configNumTests;
  logic        configStop;

  logic        statusValid;
  logic [31:0] statusErrorCount;
  logic [63:0] statusDataCount;
  logic        statusStop;

  logic        resultValid;
  logic        resultPass;
  logic        resultTimeout;
  logic [15:0] resultRunsDone;
  logic [31:0] resultErrorTotal;
  logic [63:0] resultDataTotal;
  logic        resultStop;

  modport slave (
    input  startValid, startAddrBase, startBlockSize, startNumTests, startNumRuns,
    output startStop,
    output configValid, configMemAddrBase, configMemBlockSize, configNumTests,
    input  configStop,
    input  statusValid, statusErrorCount, statusDataCount,
    output statusStop,
    output resultValid, resultPass, resultTimeout, resultRunsDone,
    output resultErrorTotal, resultDataTotal,
    input  resultStop
  );

  modport master (
    output startValid, startAddrBase, startBlockSize, startNumTests, startNumRuns,
    input  startStop,
    input  configValid, configMemAddrBase, configMemBlockSize, configNumTests,
    output configStop,
    output statusValid, statusErrorCount, statusDataCount,
    input  statusStop,
    input  resultValid, resultPass, resultTimeout, resultRunsDone,
    input  resultErrorTotal, resultDataTotal,
    output resultStop
  );

endinterface

// File: rtl/smi_mem_fuzz_test_sequencer_toggle_buffer.sv
// Single-entry output holding register: captures a word on load and presents
// it with valid until the consumer drops stop.
module smiSelfLinkToggleBuffer #(
  parameter int Width = 114
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             loadValid_i,
  input  logic [Width-1:0] loadData_i,
  output logic             outValid_o,
  output logic [Width-1:0] outData_o,
  input  logic             outStop_i
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_q <= 1'b0;
    end else if (loadValid_i) begin
      valid_q <= 1'b1;
    end else if (valid_q && !outStop_i) begin
      valid_q <= 1'b0;
    end
  end

  // Data has no reset; it is only observed while valid_q is set.
  always_ff @(posedge clk) begin
    if (loadValid_i) begin
      data_q <= loadData_i;
    end
  end

  assign outValid_o = valid_q;
  assign outData_o  = data_q;

endmodule

// File: rtl/smi_mem_fuzz_test_sequencer.sv
// Runs a campaign of fuzz-tester runs over consecutive memory windows and
// reports accumulated error/data totals once all runs finish or one times out.
module smi_mem_fuzz_test_sequencer
  import smi_mem_fuzz_test_sequencer_pkg::*;
#(
  parameter logic [31:0] TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic                          clk,
  input  logic                          srst,
  smi_mem_fuzz_test_sequencer_if.slave  bus
);

  state_e      state_q;
  logic        startStop_q;
  logic        statusStop_q;
  logic        configValid_q;
  logic        loaded_q;

  logic [63:0] configAddr_q;
  logic [31:0] blockSize_q;
  logic [31:0] numTests_q;
  logic [15:0] numRuns_q;
  logic [15:0] runsDone_q;
  logic [31:0] errTotal_q;
  logic [63:0] dataTotal_q;
  logic        timeout_q;
  logic [31:0] timer_q;

  logic        startAccept_d;
  logic        statusAccept_d;
  logic        lastRun_d;
  logic [31:0] errSum_d;
  logic        bufLoad_d;
  logic        bufValid_d;
  result_t     resultIn_d;
  result_t     resultOut_d;

  assign startAccept_d  = bus.startValid && !startStop_q;
  assign statusAccept_d = bus.statusValid && !statusStop_q && (state_q == WaitStatus);
  assign lastRun_d      = (runsDone_q + 16'd1) == numRuns_q;
  assign errSum_d       = satAdd32(errTotal_q, bus.statusErrorCount);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= Reset;
      startStop_q   <= 1'b1;
      statusStop_q  <= 1'b1;
      configValid_q <= 1'b0;
      loaded_q      <= 1'b0;
    end else begin
      case (state_q)
        Reset: begin
          state_q      <= Idle;
          startStop_q  <= 1'b0;
          statusStop_q <= 1'b0;
        end
        Idle: begin
          errTotal_q  <= '0;
          dataTotal_q <= '0;
          runsDone_q  <= '0;
          timeout_q   <= 1'b0;
          if (startAccept_d) begin
            configAddr_q <= bus.startAddrBase;
            blockSize_q  <= bus.startBlockSize;
            numTests_q   <= bus.startNumTests;
            numRuns_q    <= bus.startNumRuns;
            startStop_q  <= 1'b1;
            statusStop_q <= 1'b1;
            if (bus.startNumRuns == 16'd0) begin
              state_q <= Report;
            end else begin
              state_q       <= IssueConfig;
              configValid_q <= 1'b1;
            end
          end
        end
        IssueConfig: begin
          if (configValid_q && !bus.configStop) begin
            state_q       <= WaitStatus;
            configValid_q <= 1'b0;
            statusStop_q  <= 1'b0;
            timer_q       <= '0;
          end
        end
        WaitStatus: begin
          // A status landing on the final timeout cycle takes priority.
          if (statusAccept_d) begin
            errTotal_q   <= errSum_d;
            dataTotal_q  <= dataTotal_q + bus.statusDataCount;
            runsDone_q   <= runsDone_q + 16'd1;
            configAddr_q <= configAddr_q + {32'd0, blockSize_q};
            statusStop_q <= 1'b1;
            if (lastRun_d) begin
              state_q <= Report;
            end else begin
              state_q       <= IssueConfig;
              configValid_q <= 1'b1;
            end
          end else if (timer_q == TimeoutCycles - 32'd1) begin
            timeout_q    <= 1'b1;
            statusStop_q <= 1'b1;
            state_q      <= Report;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        Report: begin
          // First cycle loads the buffer from settled totals; then wait for the drain.
          if (!loaded_q) begin
            loaded_q <= 1'b1;
          end else if (bufValid_d && !bus.resultStop) begin
            state_q      <= Idle;
            loaded_q     <= 1'b0;
            startStop_q  <= 1'b0;
            statusStop_q <= 1'b0;
          end
        end
        default: begin
          state_q <= Reset;
        end
      endcase
    end
  end

  assign bufLoad_d = (state_q == Report) && !loaded_q;

  always_comb begin
    resultIn_d            = '0;
    resultIn_d.pass       = (errTotal_q == 32'd0) && !timeout_q;
    resultIn_d.timeout    = timeout_q;
    resultIn_d.runsDone   = runsDone_q;
    resultIn_d.errorTotal = errTotal_q;
    resultIn_d.dataTotal  = dataTotal_q;
  end

  logic [ResultWidth-1:0] bufData_d;

  smiSelfLinkToggleBuffer #(
    .Width (ResultWidth)
  ) uResultBuffer (
    .clk         (clk),
    .srst        (srst),
    .loadValid_i (bufLoad_d),
    .loadData_i  (resultIn_d),
    .outValid_o  (bufValid_d),
    .outData_o   (bufData_d),
    .outStop_i   (bus.resultStop)
  );

  assign resultOut_d = result_t'(bufData_d);

  assign bus.startStop          = startStop_q;
  assign bus.statusStop         = statusStop_q;
  assign bus.configValid        = configValid_q;
  assign bus.configMemAddrBase  = configAddr_q;
  assign bus.configMemBlockSize = blockSize_q;
  assign bus.configNumTests     = numTests_q;
  assign bus.resultValid        = bufValid_d;
  assign bus.resultPass         = resultOut_d.pass;
  assign bus.resultTimeout      = resultOut_d.timeout;
  assign bus.resultRunsDone     = resultOut_d.runsDone;
  assign bus.resultErrorTotal   = resultOut_d.errorTotal;
  assign bus.resultDataTotal    = resultOut_d.dataTotal;

endmodule

// File: tb/tb_smi_mem_fuzz_test_sequencer.sv
// Directed bench for the fuzz-test campaign sequencer with hand-computed
// expectations; the DUT uses an 8-cycle status timeout.
module tb_smi_mem_fuzz_test_sequencer;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   cfgCount   = 0;
  int   resCount   = 0;

  smi_mem_fuzz_test_sequencer_if bus ();

  smi_mem_fuzz_test_sequencer #(
    .TimeoutCycles (32'd8)
  ) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Count completed config and result handshakes to prove single transfers.
  always @(posedge clk) begin
    if (bus.configValid && !bus.configStop) cfgCount++;
    if (bus.resultValid && !bus.resultStop) resCount++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] base, input logic [31:0] size,
                               input logic [31:0] tests, input logic [15:0] runs);
    bit done = 0;
    bus.startValid     = 1'b1;
    bus.startAddrBase  = base;
    bus.startBlockSize = size;
    bus.startNumTests  = tests;
    bus.startNumRuns   = runs;
    for (int i = 0; i < 40 && !done; i++) begin
      done = !bus.startStop;
      tick();
    end
    bus.startValid = 1'b0;
    checkOutput("start_accept", done, 1);
  endtask

  task automatic expectConfig(input string tag, input logic [63:0] base, input logic [31:0] size,
                              input logic [31:0] tests, input int stallCycles);
    bit seen = 0;
    bus.configStop = (stallCycles > 0);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.configValid) seen = 1;
      else tick();
    end
    checkOutput({tag, "_cfgValid"}, seen, 1);
    if (seen) begin
      checkOutput({tag, "_cfgBase"}, bus.configMemAddrBase, base);
      checkOutput({tag, "_cfgSize"}, bus.configMemBlockSize, size);
      checkOutput({tag, "_cfgTests"}, bus.configNumTests, tests);
      for (int i = 0; i < stallCycles; i++) begin
        tick();
        checkOutput({tag, "_cfgHold"}, bus.configValid, 1);
        checkOutput({tag, "_cfgHoldBase"}, bus.configMemAddrBase, base);
      end
      bus.configStop = 1'b0;
      tick();
      checkOutput({tag, "_cfgDone"}, bus.configValid, 0);
    end
    bus.configStop = 1'b0;
  endtask

  task automatic giveStatus(input logic [31:0] err, input logic [63:0] data, input int delay);
    bit done = 0;
    repeat (delay) tick();
    bus.statusValid      = 1'b1;
    bus.statusErrorCount = err;
    bus.statusDataCount  = data;
    for (int i = 0; i < 40 && !done; i++) begin
      done = !bus.statusStop;
      tick();
    end
    bus.statusValid = 1'b0;
    checkOutput("status_accept", done, 1);
  endtask

  task automatic waitResult(input string tag, input logic pass, input logic tmo,
                            input logic [15:0] runs, input logic [31:0] err,
                            input logic [63:0] data, input int stallCycles);
    bit seen = 0;
    bus.resultStop = (stallCycles > 0);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.resultValid) seen = 1;
      else tick();
    end
    checkOutput({tag, "_resValid"}, seen, 1);
    if (seen) begin
      checkOutput({tag, "_pass"}, bus.resultPass, pass);
      checkOutput({tag, "_timeout"}, bus.resultTimeout, tmo);
      checkOutput({tag, "_runs"}, bus.resultRunsDone, runs);
      checkOutput({tag, "_errors"}, bus.resultErrorTotal, err);
      checkOutput({tag, "_data"}, bus.resultDataTotal, data);
      for (int i = 0; i < stallCycles; i++) begin
        tick();
        checkOutput({tag, "_resHold"}, bus.resultValid, 1);
        checkOutput({tag, "_resHoldData"}, bus.resultDataTotal, data);
        checkOutput({tag, "_resHoldErr"}, bus.resultErrorTotal, err);
      end
      bus.resultStop = 1'b0;
      tick();
      checkOutput({tag, "_resDone"}, bus.resultValid, 0);
    end
    bus.resultStop = 1'b0;
  endtask

  initial begin
    int cfg0;
    int res0;
    int n;
    bus.startValid       = 1'b0;
    bus.startAddrBase    = '0;
    bus.startBlockSize   = '0;
    bus.startNumTests    = '0;
    bus.startNumRuns     = '0;
    bus.configStop       = 1'b0;
    bus.statusValid      = 1'b0;
    bus.statusErrorCount = '0;
    bus.statusDataCount  = '0;
    bus.resultStop       = 1'b0;

    srst = 1'b1;
    repeat (3) tick();
    checkOutput("rst_configValid", bus.configValid, 0);
    checkOutput("rst_resultValid", bus.resultValid, 0);
    checkOutput("rst_startStop", bus.startStop, 1);
    checkOutput("rst_statusStop", bus.statusStop, 1);
    srst = 1'b0;

    // Three clean runs over consecutive 1 KiB windows.
    cfg0 = cfgCount;
    applyStimulus(64'h1000, 32'h400, 32'd4, 16'd3);
    checkOutput("s1_cfgNextCycle", bus.configValid, 1);
    expectConfig("s1r0", 64'h1000, 32'h400, 32'd4, 0);
    giveStatus(32'd0, 64'd32, 2);
    expectConfig("s1r1", 64'h1400, 32'h400, 32'd4, 0);
    giveStatus(32'd0, 64'd32, 2);
    expectConfig("s1r2", 64'h1800, 32'h400, 32'd4, 0);
    giveStatus(32'd0, 64'd32, 2);
    waitResult("s1", 1'b1, 1'b0, 16'd3, 32'd0, 64'd96, 0);
    checkOutput("s1_cfgTransfers", cfgCount - cfg0, 3);

    // Zero runs goes straight to the result.
    cfg0 = cfgCount;
    res0 = resCount;
    applyStimulus(64'h2000, 32'h100, 32'd1, 16'd0);
    waitResult("s2", 1'b1, 1'b0, 16'd0, 32'd0, 64'd0, 0);
    checkOutput("s2_noConfig", cfgCount - cfg0, 0);
    checkOutput("s2_oneResult", resCount - res0, 1);

    // Error saturation, data wrap and address wrap across 2^64.
    applyStimulus(64'hFFFF_FFFF_FFFF_FC00, 32'h400, 32'd2, 16'd2);
    expectConfig("s3r0", 64'hFFFF_FFFF_FFFF_FC00, 32'h400, 32'd2, 0);
    giveStatus(32'hFFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    expectConfig("s3r1", 64'h0, 32'h400, 32'd2, 0);
    giveStatus(32'h20, 64'd2, 1);
    waitResult("s3", 1'b0, 1'b0, 16'd2, 32'hFFFF_FFFF, 64'd1, 0);

    // Status on the last permitted wait cycle beats the timeout.
    applyStimulus(64'h4000, 32'h80, 32'd3, 16'd1);
    expectConfig("s4", 64'h4000, 32'h80, 32'd3, 0);
    giveStatus(32'd0, 64'd8, 7);
    waitResult("s4", 1'b1, 1'b0, 16'd1, 32'd0, 64'd8, 0);

    // No status: 8 wait cycles, then one cycle to load the result buffer.
    applyStimulus(64'h5000, 32'h10, 32'd1, 16'd1);
    expectConfig("s5", 64'h5000, 32'h10, 32'd1, 0);
    n = 0;
    while (n < 40 && !bus.resultValid) begin
      tick();
      n++;
    end
    checkOutput("s5_timeoutLatency", n, 9);
    waitResult("s5", 1'b0, 1'b1, 16'd0, 32'd0, 64'd0, 0);
    bus.statusValid      = 1'b1;
    bus.statusErrorCount = 32'd5;
    bus.statusDataCount  = 64'd100;
    checkOutput("s5_lateStatusDrained", bus.statusStop, 0);
    tick();
    bus.statusValid = 1'b0;
    applyStimulus(64'h6000, 32'h10, 32'd1, 16'd0);
    waitResult("s5clean", 1'b1, 1'b0, 16'd0, 32'd0, 64'd0, 0);

    // Backpressure on config and result.
    cfg0 = cfgCount;
    res0 = resCount;
    applyStimulus(64'h2000, 32'h100, 32'd7, 16'd1);
    expectConfig("s6", 64'h2000, 32'h100, 32'd7, 5);
    giveStatus(32'd3, 64'd64, 0);
    waitResult("s6", 1'b0, 1'b0, 16'd1, 32'd3, 64'd64, 3);
    checkOutput("s6_oneConfig", cfgCount - cfg0, 1);
    checkOutput("s6_oneResult", resCount - res0, 1);

    // Reset during WaitStatus abandons the campaign.
    res0 = resCount;
    applyStimulus(64'h7000, 32'h40, 32'd2, 16'd2);
    expectConfig("s7", 64'h7000, 32'h40, 32'd2, 0);
    tick();
    srst = 1'b1;
    tick();
    checkOutput("s7_rstConfigValid", bus.configValid, 0);
    checkOutput("s7_rstResultValid", bus.resultValid, 0);
    checkOutput("s7_rstStartStop", bus.startStop, 1);
    checkOutput("s7_rstStatusStop", bus.statusStop, 1);
    srst = 1'b0;
    tick();
    applyStimulus(64'h3000, 32'h20, 32'd5, 16'd1);
    expectConfig("s7new", 64'h3000, 32'h20, 32'd5, 0);
    giveStatus(32'd0, 64'd16, 1);
    waitResult("s7new", 1'b1, 1'b0, 16'd1, 32'd0, 64'd16, 0);
    checkOutput("s7_onlyNewResult", resCount - res0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
